// File: rtl/dcc_pkg.sv
// Shared types and defaults for the DCC command table.
// Scanner states, width defaults and a clog2 helper.
package dcc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_FETCH,
    S_PRESENT
  } scan_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dcc_cmd_table_if.sv
// Host register port and encoder handshake of the DCC command table.
// master drives host/encoder requests, slave is the table.
interface dcc_cmd_table_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) ();

  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_din;
  logic              host_wr;
  logic              host_clr;
  logic              host_rd;
  logic [DATA_W-1:0] host_dout;
  logic              host_rd_valid;
  logic              enc_valid;
  logic              enc_ready;
  logic [DATA_W-1:0] enc_data;
  logic [ADDR_W-1:0] enc_index;
  logic              scan_wrap;
  logic [ADDR_W:0]   active_count;

  modport master (
    output host_addr, host_din, host_wr,
    output host_clr, host_rd, enc_ready,
    input  host_dout, host_rd_valid,
    input  enc_valid, enc_data, enc_index,
    input  scan_wrap, active_count
  );

  modport slave (
    input  host_addr, host_din, host_wr,
    input  host_clr, host_rd, enc_ready,
    output host_dout, host_rd_valid,
    output enc_valid, enc_data, enc_index,
    output scan_wrap, active_count
  );

endinterface

// File: rtl/dcc_tdp_ram.sv
// Two-port RAM: port A read/write with write-through,
// port B read-only, both with one cycle of read latency.
module dcc_tdp_ram
  import dcc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     addr_a,
  input  logic [DATA_W-1:0] din_a,
  input  logic              we_a,
  input  logic              re_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic [AW-1:0]     addr_b,
  input  logic              re_b,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a <= '0;
    end else if (re_a) begin
      dout_a <= we_a ? din_a : mem[addr_a];
    end
  end

  // B forwards a colliding A write so the scanner never sees stale data
  always_ff @(posedge clk) begin
    if (re_b) begin
      if (we_a && addr_a == addr_b) dout_b <= din_a;
      else                          dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/dcc_cmd_table.sv
// DCC command table: host-managed entries plus a round-robin
// refresh scanner feeding the packet encoder.
module dcc_cmd_table
  import dcc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic             clk,
  input logic             reset_n,
  dcc_cmd_table_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0]  valid;
  logic [ADDR_W:0]   count;
  logic              rd_valid_q;
  logic [DATA_W-1:0] ram_a_q;
  logic [DATA_W-1:0] ram_b_q;

  scan_state_e       state;
  logic [ADDR_W-1:0] ptr;
  logic              enc_valid_q;
  logic [DATA_W-1:0] enc_data_q;
  logic [ADDR_W-1:0] enc_index_q;
  logic              wrap_q;

  logic wr, clr, cnt_inc, cnt_dec;
  logic hit_wr, hit_clr, fetch_drop;

  assign wr      = bus.host_wr;
  assign clr     = bus.host_clr && !bus.host_wr;
  assign cnt_inc = wr  && !valid[bus.host_addr];
  assign cnt_dec = clr &&  valid[bus.host_addr];

  assign hit_wr  = wr  && bus.host_addr == ptr;
  assign hit_clr = clr && bus.host_addr == ptr;
  assign fetch_drop = !hit_wr && (hit_clr || !valid[ptr]);

  dcc_tdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst_n  (reset_n),
    .addr_a (bus.host_addr),
    .din_a  (bus.host_din),
    .we_a   (bus.host_wr),
    .re_a   (bus.host_rd),
    .dout_a (ram_a_q),
    .addr_b (ptr),
    .re_b   (state == S_SEARCH),
    .dout_b (ram_b_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid      <= '0;
      count      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.host_rd;
      if (wr)       valid[bus.host_addr] <= 1'b1;
      else if (clr) valid[bus.host_addr] <= 1'b0;
      if (cnt_inc && count != CNT_MAX)
        count <= count + 1'b1;
      else if (cnt_dec && count != '0)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      enc_valid_q <= 1'b0;
      enc_data_q  <= '0;
      enc_index_q <= '0;
      wrap_q      <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (count != '0) state <= S_SEARCH;
        end
        S_SEARCH: begin
          if (count == '0) begin
            state <= S_IDLE;
          end else if (valid[ptr]) begin
            state <= S_FETCH;
          end else begin
            ptr    <= ptr + 1'b1;
            wrap_q <= &ptr;
          end
        end
        S_FETCH: begin
          if (fetch_drop) begin
            ptr    <= ptr + 1'b1;
            wrap_q <= &ptr;
            state  <= S_SEARCH;
          end else begin
            enc_data_q  <= hit_wr ? bus.host_din : ram_b_q;
            enc_index_q <= ptr;
            enc_valid_q <= 1'b1;
            state       <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (bus.enc_ready) begin
            enc_valid_q <= 1'b0;
            ptr         <= ptr + 1'b1;
            wrap_q      <= &ptr;
            state       <= S_SEARCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.host_dout     = ram_a_q;
  assign bus.host_rd_valid = rd_valid_q;
  assign bus.enc_valid     = enc_valid_q;
  assign bus.enc_data      = enc_data_q;
  assign bus.enc_index     = enc_index_q;
  assign bus.scan_wrap     = wrap_q;
  assign bus.active_count  = count;

endmodule

// File: tb/tb_dcc_cmd_table.sv
// Bench for dcc_cmd_table: scenario tasks with a scoreboard
// of expected encoder presentations.
module tb_dcc_cmd_table;
  import dcc_pkg::*;

  typedef struct {
    logic [8:0]  idx;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   wraps = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  dcc_cmd_table_if #(.DATA_W(32), .ADDR_W(9)) bus ();

  dcc_cmd_table #(.DATA_W(32), .ADDR_W(9)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  function automatic exp_t mk(input int i, input logic [31:0] d);
    exp_t e;
    e.idx  = 9'(i);
    e.data = d;
    return e;
  endfunction

  // one host cycle, driven at a negedge; returns at the next negedge
  task automatic host_cycle(input int a, input logic [31:0] d,
                            input logic w, input logic c,
                            input logic r);
    bus.host_addr = 9'(a);
    bus.host_din  = d;
    bus.host_wr   = w;
    bus.host_clr  = c;
    bus.host_rd   = r;
    @(negedge clk);
    bus.host_wr  = 1'b0;
    bus.host_clr = 1'b0;
    bus.host_rd  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (sb.size() > 0) begin
      if (cyc == budget) begin
        n_vec++; n_err++;
        $display("FAIL drain_timeout: %0d left, want 0", sb.size());
        sb.delete();
        break;
      end
      if (bus.scan_wrap) wraps++;
      if (bus.enc_valid && bus.enc_ready) begin
        e = sb.pop_front();
        n_vec++;
        if (bus.enc_index !== e.idx || bus.enc_data !== e.data) begin
          n_err++;
          $display("FAIL enc_out: got %0d/%h want %0d/%h",
                   bus.enc_index, bus.enc_data, e.idx, e.data);
        end
      end
      if (sb.size() > 0) begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.enc_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL wait_valid: enc_valid 0 want 1");
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if (bus.enc_valid !== 1'b0 || bus.active_count !== '0 ||
        bus.host_dout !== '0 || bus.host_rd_valid !== 1'b0 ||
        bus.enc_data !== '0 || bus.enc_index !== '0 ||
        bus.scan_wrap !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outs: ev %b cnt %0d dout %h want all 0",
               bus.enc_valid, bus.active_count, bus.host_dout);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.scan_wrap) wraps++;
    end
    n_vec++;
    if (bus.enc_valid !== 1'b0 || bus.active_count !== '0) begin
      n_err++;
      $display("FAIL idle_outs: ev %b cnt %0d want 0 0",
               bus.enc_valid, bus.active_count);
    end
    n_vec++;
    if (dut.state !== S_IDLE) begin
      n_err++;
      $display("FAIL idle_state: got %0d want %0d", dut.state, S_IDLE);
    end
    n_vec++;
    if (wraps != 0) begin
      n_err++;
      $display("FAIL idle_wrap: got %0d want 0", wraps);
    end
  endtask

  task automatic test_scan;
    bus.enc_ready = 1'b1;
    host_cycle(3, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
    host_cycle(7, 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(3, 32'hA5A5_0001));
      sb.push_back(mk(7, 32'h0000_00FF));
    end
    wraps = 0;
    drain(3000);
    n_vec++;
    if (bus.active_count !== 10'd2) begin
      n_err++;
      $display("FAIL scan_count: got %0d want 2", bus.active_count);
    end
    n_vec++;
    if (wraps != 2) begin
      n_err++;
      $display("FAIL scan_wrap: got %0d want 2", wraps);
    end
  endtask

  task automatic test_stall;
    bit ok;
    int bad;
    @(negedge clk);
    bus.enc_ready = 1'b0;
    wait_valid(2000, ok);
    if (ok) begin
      n_vec++;
      if (bus.enc_index !== 9'd3 || bus.enc_data !== 32'hA5A5_0001) begin
        n_err++;
        $display("FAIL stall_first: got %0d/%h want 3/a5a50001",
                 bus.enc_index, bus.enc_data);
      end
      host_cycle(3, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
        if (!bus.enc_valid || bus.enc_index !== 9'd3 ||
            bus.enc_data !== 32'hA5A5_0001) bad++;
        @(negedge clk);
      end
      n_vec++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
      end
      sb.push_back(mk(3, 32'hA5A5_0001));
      sb.push_back(mk(7, 32'h0000_00FF));
      sb.push_back(mk(3, 32'h1234_5678));
      bus.enc_ready = 1'b1;
      drain(3000);
    end
  endtask

  task automatic test_host;
    host_cycle(5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (bus.host_dout !== 32'hDEAD_BEEF || bus.host_rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wr_through: got %h/%b want deadbeef/1",
               bus.host_dout, bus.host_rd_valid);
    end
    n_vec++;
    if (bus.active_count !== 10'd3) begin
      n_err++;
      $display("FAIL wr_count: got %0d want 3", bus.active_count);
    end
    @(negedge clk);
    n_vec++;
    if (bus.host_rd_valid !== 1'b0 || bus.host_dout !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL rd_hold: got %h/%b want deadbeef/0",
               bus.host_dout, bus.host_rd_valid);
    end
    host_cycle(5, 32'hCAFE_0005, 1'b1, 1'b1, 1'b0);
    host_cycle(5, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (bus.host_dout !== 32'hCAFE_0005 || bus.active_count !== 10'd3) begin
      n_err++;
      $display("FAIL wr_clr: got %h cnt %0d want cafe0005 cnt 3",
               bus.host_dout, bus.active_count);
    end
    n_vec++;
    if (dut.valid[5] !== 1'b1) begin
      n_err++;
      $display("FAIL wr_clr_valid: got %b want 1", dut.valid[5]);
    end
    host_cycle(5, 32'h0, 1'b0, 1'b1, 1'b0);
    host_cycle(5, 32'h0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (bus.active_count !== 10'd2) begin
      n_err++;
      $display("FAIL clr_count: got %0d want 2", bus.active_count);
    end
  endtask

  task automatic test_fetch_clear;
    bit ok;
    ok = 1'b0;
    bus.enc_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (dut.state == S_FETCH && dut.ptr == 9'd7) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL fetch7_wait: got none want fetch at 7");
    end else begin
      host_cycle(7, 32'h0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if (bus.active_count !== 10'd1 || dut.ptr !== 9'd8 ||
          dut.state !== S_SEARCH) begin
        n_err++;
        $display("FAIL fetch_drop: cnt %0d ptr %0d want 1 8",
                 bus.active_count, dut.ptr);
      end
      sb.push_back(mk(3, 32'h1234_5678));
      sb.push_back(mk(3, 32'h1234_5678));
      drain(3000);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    @(negedge clk);
    bus.enc_ready = 1'b0;
    wait_valid(2000, ok);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.enc_valid !== 1'b0 || bus.active_count !== '0) begin
      n_err++;
      $display("FAIL async_rst: ev %b cnt %0d want 0 0",
               bus.enc_valid, bus.active_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    n_vec++;
    if (dut.state !== S_IDLE || bus.enc_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_rst: state %0d ev %b want 0 0",
               dut.state, bus.enc_valid);
    end
    host_cycle(3, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (bus.host_dout !== 32'h1234_5678 || bus.host_rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ram_keep3: got %h want 12345678", bus.host_dout);
    end
    host_cycle(7, 32'h0, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if (bus.host_dout !== 32'h0000_00FF) begin
      n_err++;
      $display("FAIL ram_keep7: got %h want 000000ff", bus.host_dout);
    end
  endtask

  initial begin
    bus.host_addr = '0;
    bus.host_din  = '0;
    bus.host_wr   = 1'b0;
    bus.host_clr  = 1'b0;
    bus.host_rd   = 1'b0;
    bus.enc_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_scan();
    test_stall();
    test_host();
    test_fetch_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
